// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Definitions shared by the pipeline sequencing controller: the FSM state
//   encoding (also exported on state_dbg), the default boot-flush length and
//   the width of the boot-flush down-counter.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_BOOT  = 2'd0,
    PC_RUN   = 2'd1,
    PC_MWAIT = 2'd2,
    PC_ERR   = 2'd3
  } pc_state_e;

  // Cycles of forced flush after reset release (legal range 1..15).
  localparam int unsigned DEF_BOOT_FLUSH = 2;

  // Wide enough for BOOT_FLUSH-1 over the whole legal range.
  localparam int unsigned BOOT_CNT_W = 4;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear and asynchronous reset.
//   Once the count reaches all-ones it holds there until clear or rst.
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  asynchronous active-high reset, count -> 0
//   inc    in  1  advance the count by one (ignored when saturated)
//   clear  in  1  synchronous clear, has priority over inc
//   q      out W  current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  logic full;

  assign full = &q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && !full) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Sequencing controller for the 3-stage pipeline (F, X/M, W). Produces the
//   stall / flush / bubble controls for the F->X and M->W pipeline registers
//   and the PC redirect select. Covers the post-reset flush, variable-latency
//   data-memory waits and branch/jump redirects, including a redirect that is
//   raised while the pipe is stalled (held pending until the access finishes).
// Ports:
//   clk              in  1       rising-edge clock
//   rst              in  1       asynchronous active-high reset
//   mem_reqM         in  1       load/store present in M this cycle
//   mem_ackM         in  1       data memory completes the M access this cycle
//   branch_takenX    in  1       X stage redirects the PC this cycle
//   stall_F          out 1       hold PC and the F->X register
//   stall_X          out 1       hold the X/M stage inputs
//   flush_X          out 1       load a NOP into the F->X register
//   bubble_M         out 1       clear reg_write/wb_sel into the M->W register
//   pc_sel_redirect  out 1       select the redirect target at the PC mux
//   mem_timeout      out 1       sticky memory-timeout error flag
//   stall_cnt        out PERF_W  saturating count of stall cycles
//   state_dbg        out 2       current FSM state encoding
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_FLUSH = DEF_BOOT_FLUSH,
  parameter int unsigned TMO_W      = 8,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_reqM,
  input  logic              mem_ackM,
  input  logic              branch_takenX,
  output logic              stall_F,
  output logic              stall_X,
  output logic              flush_X,
  output logic              bubble_M,
  output logic              pc_sel_redirect,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [1:0]        state_dbg
);

  pc_state_e             state;
  logic [BOOT_CNT_W-1:0] boot_cnt;
  logic [TMO_W-1:0]      wait_cnt;
  logic [TMO_W-1:0]      wait_next;
  logic                  wait_tmo;
  logic                  pending_redirect;
  logic                  stall_run;

  // A memory access that is not acknowledged in its first M cycle.
  assign stall_run = mem_reqM & ~mem_ackM;

  // Timeout fires on the cycle the wait counter would reach all-ones.
  assign wait_next = wait_cnt + TMO_W'(1);
  assign wait_tmo  = (wait_next == '1);

  assign state_dbg = state;

  // Outputs decode from the current state and this cycle's inputs so that
  // a zero-wait ack or a branch takes effect with no added latency.
  always_comb begin
    stall_F         = 1'b0;
    stall_X         = 1'b0;
    flush_X         = 1'b0;
    bubble_M        = 1'b0;
    pc_sel_redirect = 1'b0;
    mem_timeout     = 1'b0;
    unique case (state)
      PC_BOOT: begin
        flush_X  = 1'b1;
        stall_F  = 1'b1;
        bubble_M = 1'b1;
      end
      PC_RUN: begin
        if (stall_run) begin
          stall_F  = 1'b1;
          stall_X  = 1'b1;
          bubble_M = 1'b1;
        end else if (branch_takenX) begin
          flush_X         = 1'b1;
          pc_sel_redirect = 1'b1;
        end
      end
      PC_MWAIT: begin
        if (mem_ackM) begin
          // Stalls drop on the ack cycle; a held or new redirect is applied
          // now, when the F->X register is free to take the NOP.
          if (pending_redirect || branch_takenX) begin
            flush_X         = 1'b1;
            pc_sel_redirect = 1'b1;
          end
        end else begin
          stall_F  = 1'b1;
          stall_X  = 1'b1;
          bubble_M = 1'b1;
        end
      end
      PC_ERR: begin
        stall_F     = 1'b1;
        stall_X     = 1'b1;
        bubble_M    = 1'b1;
        mem_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= PC_BOOT;
      boot_cnt         <= BOOT_CNT_W'(BOOT_FLUSH - 1);
      wait_cnt         <= '0;
      pending_redirect <= 1'b0;
    end else begin
      unique case (state)
        PC_BOOT: begin
          if (boot_cnt == '0) begin
            state <= PC_RUN;
          end else begin
            boot_cnt <= boot_cnt - BOOT_CNT_W'(1);
          end
        end
        PC_RUN: begin
          if (stall_run) begin
            state            <= PC_MWAIT;
            wait_cnt         <= TMO_W'(1);
            pending_redirect <= branch_takenX;
          end
        end
        PC_MWAIT: begin
          if (mem_ackM) begin
            state            <= PC_RUN;
            pending_redirect <= 1'b0;
          end else begin
            wait_cnt <= wait_next;
            if (branch_takenX) begin
              pending_redirect <= 1'b1;
            end
            if (wait_tmo) begin
              state <= PC_ERR;
            end
          end
        end
        PC_ERR: ;
        default: state <= PC_BOOT;
      endcase
    end
  end

  // stall_X is never high in BOOT, so BOOT cycles are not counted.
  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_X),
    .clear (1'b0),
    .q     (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl (BOOT_FLUSH=2, TMO_W=4, PERF_W=4). A
//   behavioural model of the controller's rules predicts every output each
//   cycle; a few literal expectations pin key moments of the scenarios.
module tb_pipe_ctrl;

  localparam int BF     = 2;
  localparam int TW     = 4;
  localparam int PW     = 4;
  localparam int TMOMAX = (1 << TW) - 1;
  localparam int SATMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_reqM = 1'b0;
  logic          mem_ackM = 1'b0;
  logic          branch_takenX = 1'b0;
  logic          stall_F, stall_X, flush_X, bubble_M, pc_sel_redirect;
  logic          mem_timeout;
  logic [PW-1:0] stall_cnt;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(
    .BOOT_FLUSH (BF),
    .TMO_W      (TW),
    .PERF_W     (PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_reqM        (mem_reqM),
    .mem_ackM        (mem_ackM),
    .branch_takenX   (branch_takenX),
    .stall_F         (stall_F),
    .stall_X         (stall_X),
    .flush_X         (flush_X),
    .bubble_M        (bubble_M),
    .pc_sel_redirect (pc_sel_redirect),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase flags plus plain counters.
  int boot_left = BF;
  bit in_wait   = 0;
  bit dead      = 0;
  bit pend      = 0;
  int missed    = 0;
  int stalls    = 0;

  always @(negedge clk) begin
    bit e_sf, e_sx, e_fx, e_bm, e_pc, e_tmo;
    int e_st;
    e_sf = 0; e_sx = 0; e_fx = 0; e_bm = 0; e_pc = 0; e_tmo = 0; e_st = 0;
    if (rst) begin
      boot_left = BF; in_wait = 0; dead = 0; pend = 0; missed = 0; stalls = 0;
      e_fx = 1; e_sf = 1; e_bm = 1; e_st = 0;
    end else if (dead) begin
      e_sf = 1; e_sx = 1; e_bm = 1; e_tmo = 1; e_st = 3;
    end else if (boot_left > 0) begin
      e_fx = 1; e_sf = 1; e_bm = 1; e_st = 0;
      boot_left--;
    end else if (in_wait) begin
      e_st = 2;
      if (mem_ackM) begin
        e_fx = pend | branch_takenX;
        e_pc = pend | branch_takenX;
        in_wait = 0;
        pend = 0;
      end else begin
        e_sf = 1; e_sx = 1; e_bm = 1;
        if (branch_takenX) pend = 1;
        missed++;
        if (missed == TMOMAX) begin
          dead = 1;
          in_wait = 0;
        end
      end
    end else begin
      e_st = 1;
      if (mem_reqM && !mem_ackM) begin
        e_sf = 1; e_sx = 1; e_bm = 1;
        in_wait = 1;
        missed = 1;
        pend = branch_takenX;
      end else if (branch_takenX) begin
        e_fx = 1; e_pc = 1;
      end
    end
    chk("stall_F", int'(stall_F), int'(e_sf));
    chk("stall_X", int'(stall_X), int'(e_sx));
    chk("flush_X", int'(flush_X), int'(e_fx));
    chk("bubble_M", int'(bubble_M), int'(e_bm));
    chk("pc_sel_redirect", int'(pc_sel_redirect), int'(e_pc));
    chk("mem_timeout", int'(mem_timeout), int'(e_tmo));
    chk("state_dbg", int'(state_dbg), e_st);
    chk("stall_cnt", int'(stall_cnt), stalls);
    if (!rst && e_sx && stalls < SATMAX) stalls++;
  end

  task automatic step(input bit req, input bit ack, input bit br);
    mem_reqM = req;
    mem_ackM = ack;
    branch_takenX = br;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_reqM = 0; mem_ackM = 0; branch_takenX = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    chk("rst_flush_X", int'(flush_X), 1);
    chk("rst_stall_F", int'(stall_F), 1);
    rst = 1'b0;

    // Boot flush: exactly two cycles, then RUN with idle controls.
    step(0, 0, 0);
    chk("boot_still_boot", int'(state_dbg), 0);
    step(0, 0, 0);
    chk("boot_to_run", int'(state_dbg), 1);
    chk("run_idle_flush", int'(flush_X), 0);

    // Zero-wait access.
    step(1, 1, 0);
    step(0, 0, 0);
    chk("zero_wait_cnt", int'(stall_cnt), 0);

    // Ack three cycles after the request.
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("wait3_cnt", int'(stall_cnt), 3);
    chk("wait3_run", int'(state_dbg), 1);

    // Branch in RUN with no stall.
    step(0, 0, 1);

    // Branch in MWAIT cycle 1, ack in cycle 4.
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    mem_reqM = 1; mem_ackM = 1; branch_takenX = 0;
    #2;
    chk("pend_ack_flush", int'(flush_X), 1);
    chk("pend_ack_redir", int'(pc_sel_redirect), 1);
    @(posedge clk);
    #1;
    step(0, 0, 0);

    // Branch coincident with a stall in RUN, applied on the ack.
    step(1, 0, 1);
    step(1, 1, 0);
    step(0, 0, 0);

    // Timeout: 15 cycles without ack, later ack ignored.
    for (int i = 0; i < TMOMAX; i++) step(1, 0, 0);
    chk("tmo_state", int'(state_dbg), 3);
    chk("tmo_flag", int'(mem_timeout), 1);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("tmo_ack_ignored", int'(state_dbg), 3);

    do_reset();
    chk("tmo_rst_flag", int'(mem_timeout), 0);
    chk("tmo_rst_state", int'(state_dbg), 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Saturation: 4 waits of 5 stall cycles each.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      step(1, 1, 0);
    end
    chk("sat_cnt", int'(stall_cnt), SATMAX);

    // Reset asserted mid-MWAIT acts immediately.
    step(1, 0, 0);
    step(1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state_dbg), 0);
    chk("async_rst_cnt", int'(stall_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_reqM = 0; mem_ackM = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("post_rst_run", int'(state_dbg), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
